// File: rtl/io_port_ctrl_pkg.sv
// Shared definitions for the memory-mapped I/O port controller.
// Optional transfer counters are enabled with IO_PORT_CNT_EN.
package io_port_ctrl_pkg;

    localparam int          IO_DATA_W = 32;
    localparam logic [2:0]  IO_FUNCT3 = 3'b111;

    typedef enum logic {
        OUT_IDLE = 1'b0,
        OUT_FULL = 1'b1
    } out_state_e;

endpackage

// File: rtl/io_port_ctrl_if.sv
// External-device side of the I/O port: output word and input word handshakes.
// master = controller, slave = external device.
interface io_port_ctrl_if
    import io_port_ctrl_pkg::*;
#(
    parameter int DATA_W = IO_DATA_W
);
    logic [DATA_W-1:0] ext_out_data;
    logic              ext_out_valid;
    logic              ext_out_ready;
    logic [DATA_W-1:0] ext_in_data;
    logic              ext_in_valid;
    logic              ext_in_ready;

    modport master (
        output ext_out_data, ext_out_valid, ext_in_ready,
        input  ext_out_ready, ext_in_data, ext_in_valid
    );

    modport slave (
        input  ext_out_data, ext_out_valid, ext_in_ready,
        output ext_out_ready, ext_in_data, ext_in_valid
    );
endinterface

// File: rtl/io_in_fifo.sv
// Parameterised synchronous circular-buffer FIFO (DEPTH a power of 2, >= 2).
module io_in_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int           AW       = $clog2(DEPTH);
    localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count_q;
    logic              push_ok, pop_ok;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: reads are gated by count.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign count   = count_q;

endmodule

// File: rtl/io_port_ctrl.sv
// I/O port controller for the single-cycle core: output holding register + input FIFO.
// Define IO_PORT_CNT_EN to add tx_count / rx_count transfer counters.
module io_port_ctrl
    import io_port_ctrl_pkg::*;
#(
    parameter int DATA_W   = IO_DATA_W,
    parameter int IN_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_strobe,
    input  logic              out_strobe,
    input  logic [DATA_W-1:0] out_data,
    output logic [DATA_W-1:0] in_data,
    output logic              stall,
`ifdef IO_PORT_CNT_EN
    output logic [15:0]       tx_count,
    output logic [15:0]       rx_count,
`endif
    io_port_ctrl_if.master    ext
);
    localparam int AW = $clog2(IN_DEPTH);

    // Input path
    logic              push, pop, fifo_full, fifo_empty, stall_in;
    logic [AW:0]       fifo_count;
    logic [DATA_W-1:0] fifo_rd;

    assign ext.ext_in_ready = ~fifo_full;
    assign push             = ext.ext_in_valid & ext.ext_in_ready;
    assign pop              = in_strobe & (fifo_count != '0);
    assign in_data          = fifo_empty ? '0 : fifo_rd;
    assign stall_in         = in_strobe & fifo_empty;

    io_in_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (IN_DEPTH)
    ) u_in_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .wr_data (ext.ext_in_data),
        .rd_data (fifo_rd),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Output path
    out_state_e        state_q, state_d;
    logic [DATA_W-1:0] out_q;
    logic              load, stall_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OUT_IDLE;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load) out_q <= out_data;
        end
    end

    // A held word is only replaced on the edge it handshakes, so it never changes under !ready.
    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        stall_out = 1'b0;
        case (state_q)
            OUT_IDLE: begin
                if (out_strobe) begin
                    load    = 1'b1;
                    state_d = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (ext.ext_out_ready) begin
                    if (out_strobe) load = 1'b1;
                    else            state_d = OUT_IDLE;
                end else if (out_strobe) begin
                    stall_out = 1'b1;
                end
            end
            default: state_d = OUT_IDLE;
        endcase
    end

    assign ext.ext_out_valid = (state_q == OUT_FULL);
    assign ext.ext_out_data  = out_q;
    assign stall             = stall_in | stall_out;

`ifdef IO_PORT_CNT_EN
    logic [15:0] tx_cnt_q, rx_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (ext.ext_out_valid & ext.ext_out_ready) tx_cnt_q <= tx_cnt_q + 1'b1;
            if (push)                                  rx_cnt_q <= rx_cnt_q + 1'b1;
        end
    end

    assign tx_count = tx_cnt_q;
    assign rx_count = rx_cnt_q;
`endif

endmodule

// File: tb/tb_io_port_ctrl.sv
// Scoreboard bench for io_port_ctrl: expected loads/stores queued at stimulus, popped by a monitor.
module tb_io_port_ctrl;
    import io_port_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_strobe, out_strobe;
    logic [31:0] out_data, in_data;
    logic        stall;
`ifdef IO_PORT_CNT_EN
    logic [15:0] tx_count, rx_count;
`endif

    io_port_ctrl_if #(.DATA_W(32)) io ();

    io_port_ctrl #(.DATA_W(32), .IN_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_strobe  (in_strobe),
        .out_strobe (out_strobe),
        .out_data   (out_data),
        .in_data    (in_data),
        .stall      (stall),
`ifdef IO_PORT_CNT_EN
        .tx_count   (tx_count),
        .rx_count   (rx_count),
`endif
        .ext        (io)
    );

    always #5 clk = ~clk;

    int          passed = 0;
    int          total  = 0;
    logic [31:0] in_q[$];
    logic [31:0] out_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every completed input-load / output handshake is checked against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_strobe && !stall) begin
                if (in_q.size() == 0) begin
                    total++;
                    $display("FAIL in_load: unexpected load got %h expected none", in_data);
                end else chk("in_load", in_data, in_q.pop_front());
            end
            if (io.ext_out_valid && io.ext_out_ready) begin
                if (out_q.size() == 0) begin
                    total++;
                    $display("FAIL out_hs: unexpected handshake got %h expected none", io.ext_out_data);
                end else chk("out_hs", io.ext_out_data, out_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_strobe = 1'b0; out_strobe = 1'b0; out_data = '0;
        io.ext_out_ready = 1'b0; io.ext_in_data = '0; io.ext_in_valid = 1'b0;
        #12;
        chk("rst_in_ready",  32'(io.ext_in_ready),  32'd1);
        chk("rst_out_valid", 32'(io.ext_out_valid), 32'd0);
        chk("rst_out_data",  io.ext_out_data,       32'd0);
        chk("rst_stall",     32'(stall),            32'd0);
        chk("rst_in_data",   in_data,               32'd0);
        step(); rst_n = 1'b1;

        // Load from an empty FIFO stalls
        step(); in_strobe = 1'b1; #1;
        chk("empty_stall", 32'(stall), 32'd1);
        chk("empty_data",  in_data,    32'd0);
        step(); #1;
        chk("empty_stall2", 32'(stall), 32'd1);

        // Push while the load is waiting: readable next cycle only
        step(); io.ext_in_valid = 1'b1; io.ext_in_data = 32'hA5A5_0001; in_q.push_back(32'hA5A5_0001); #1;
        chk("nobypass_stall", 32'(stall), 32'd1);
        step(); io.ext_in_valid = 1'b0; #1;
        chk("push_stall_lo", 32'(stall), 32'd0);
        chk("push_data",     in_data,    32'hA5A5_0001);
        step(); in_strobe = 1'b0; #1;
        chk("pop_count", 32'(dut.fifo_count), 32'd0);

        // Fill to full; a fifth word is refused
        for (int i = 1; i <= 4; i++) begin
            step(); io.ext_in_valid = 1'b1; io.ext_in_data = 32'(i); in_q.push_back(32'(i));
        end
        step(); io.ext_in_data = 32'd5; #1;
        chk("full_ready", 32'(io.ext_in_ready), 32'd0);
        step(); #1;
        chk("full_count", 32'(dut.fifo_count), 32'd4);
        io.ext_in_valid = 1'b0; in_strobe = 1'b1;
        repeat (3) step();
        step(); in_strobe = 1'b0; #1;
        chk("drain_count", 32'(dut.fifo_count), 32'd0);

        // Pointer wrap
        for (int i = 0; i < 6; i++) begin
            step(); io.ext_in_valid = 1'b1; io.ext_in_data = 32'h100 + 32'(i); in_q.push_back(32'h100 + 32'(i));
            step(); io.ext_in_valid = 1'b0; in_strobe = 1'b1;
            step(); in_strobe = 1'b0;
        end

        // Output with a stalled device
        step(); out_strobe = 1'b1; out_data = 32'h1234; out_q.push_back(32'h1234); #1;
        chk("out_first_stall", 32'(stall), 32'd0);
        step(); out_data = 32'h5678; #1;
        chk("out_valid",      32'(io.ext_out_valid), 32'd1);
        chk("out_stall",      32'(stall),            32'd1);
        chk("out_hold",       io.ext_out_data,       32'h1234);
        step(); #1;
        chk("out_hold2",      io.ext_out_data,       32'h1234);
        io.ext_out_ready = 1'b1; out_q.push_back(32'h5678); #1;
        chk("out_unstall",    32'(stall),            32'd0);
        step(); out_strobe = 1'b0; #1;
        chk("out_replaced",   io.ext_out_data,       32'h5678);
        step(); #1;
        chk("out_idle",       32'(io.ext_out_valid), 32'd0);

        // Back-to-back stores with ready high
        for (int i = 0; i < 4; i++) begin
            step(); out_strobe = 1'b1; out_data = 32'hB0 + 32'(i); out_q.push_back(32'hB0 + 32'(i)); #1;
            chk("tput_stall", 32'(stall), 32'd0);
        end
        step(); out_strobe = 1'b0;
        step(); #1;
        chk("tput_idle", 32'(io.ext_out_valid), 32'd0);

        // Simultaneous push/pop at count 2, then reset mid-burst
        step(); io.ext_in_valid = 1'b1; io.ext_in_data = 32'h21; in_q.push_back(32'h21);
        step(); io.ext_in_data = 32'h22; in_q.push_back(32'h22);
        step(); io.ext_in_data = 32'h23; in_q.push_back(32'h23); in_strobe = 1'b1;
        step(); io.ext_in_valid = 1'b0; in_strobe = 1'b0; #1;
        chk("pp_count", 32'(dut.fifo_count), 32'd2);
        chk("pp_head",  in_data,             32'h22);
        step(); out_strobe = 1'b1; out_data = 32'hDEAD; io.ext_out_ready = 1'b0;
        step(); out_strobe = 1'b0; in_strobe = 1'b1; #1;
        chk("burst_valid", 32'(io.ext_out_valid), 32'd1);
        step(); in_strobe = 1'b0; #1;
        chk("burst_count", 32'(dut.fifo_count), 32'd1);
        #2 rst_n = 1'b0; in_q.delete(); #1;
        chk("arst_count", 32'(dut.fifo_count),  32'd0);
        chk("arst_valid", 32'(io.ext_out_valid), 32'd0);
        chk("arst_data",  io.ext_out_data,       32'd0);
        chk("arst_in",    in_data,               32'd0);
        step(); step(); rst_n = 1'b1;
        step(); in_strobe = 1'b1; #1;
        chk("post_rst_stall", 32'(stall), 32'd1);
        step(); in_strobe = 1'b0;

`ifdef IO_PORT_CNT_EN
        chk("cnt_tx_rst", 32'(tx_count), 32'd0);
        chk("cnt_rx_rst", 32'(rx_count), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(); io.ext_in_valid = 1'b1; io.ext_in_data = 32'h300 + 32'(i); in_q.push_back(32'h300 + 32'(i));
            step(); io.ext_in_valid = 1'b0; in_strobe = 1'b1;
            step(); in_strobe = 1'b0;
        end
        io.ext_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); out_strobe = 1'b1; out_data = 32'hC0 + 32'(i); out_q.push_back(32'hC0 + 32'(i));
        end
        step(); out_strobe = 1'b0;
        step(); step(); #1;
        chk("cnt_tx", 32'(tx_count), 32'd3);
        chk("cnt_rx", 32'(rx_count), 32'd5);
        force dut.rx_cnt_q = 16'hFFFF;
        #1 release dut.rx_cnt_q;
        step(); io.ext_in_valid = 1'b1; io.ext_in_data = 32'h3FF; in_q.push_back(32'h3FF);
        step(); io.ext_in_valid = 1'b0; in_strobe = 1'b1; #1;
        chk("cnt_rx_wrap", 32'(rx_count), 32'd0);
        step(); in_strobe = 1'b0;
`endif

        step(); step();
        chk("in_q_empty",  32'(in_q.size()),  32'd0);
        chk("out_q_empty", 32'(out_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/io_port_ctrl.md
# io_port_ctrl

Memory-mapped I/O port controller sitting between the single-cycle RISC-V core and external devices. It answers the core's I/O strobes: input-load (`lw` with funct3 = 111, which asserts InputSRC) and output-store (`sw` with funct3 = 111, which asserts OutputSRC). Output words go through a one-entry holding register with a valid/ready handshake. Input words arrive through a small FIFO with a valid/ready handshake. `stall` is driven back to the core's PC enable whenever a strobe cannot complete in the current cycle.

## Interface
Parameters:
- `DATA_W`, 32, word width on the core side and the external side
- `IN_DEPTH`, 4, input FIFO depth in words; must be a power of 2 and ≥ 2

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `in_strobe`  in  1  InputSRC from control unit; core is executing an input-load
- `out_strobe`  in  1  OutputSRC from control unit; core is executing an output-store
- `out_data`  in  DATA_W  RD2 from the register file; the word to send
- `in_data`  out  DATA_W  word returned to the core result mux
- `stall`  out  1  core must hold PC and register writes this cycle
- `ext_out_data`  out  DATA_W  word presented to the external device
- `ext_out_valid`  out  1  `ext_out_data` is valid
- `ext_out_ready`  in  1  external device accepts the word this cycle
- `ext_in_data`  in  DATA_W  word from the external device
- `ext_in_valid`  in  1  `ext_in_data` is valid
- `ext_in_ready`  out  1  FIFO can accept a word this cycle

## Operation
- Output FSM has two states.
  - OUT_IDLE → OUT_FULL: `out_strobe` & !stall_out; `out_data` is captured into `ext_out_data`.
  - OUT_FULL → OUT_IDLE: `ext_out_ready` & !`out_strobe`.
  - OUT_FULL → OUT_FULL (new word replaces the old): `ext_out_ready` & `out_strobe`.
  - `ext_out_valid` = (state == OUT_FULL).
- stall_out = `out_strobe` & OUT_FULL & !`ext_out_ready`.
- Input FIFO:
  - Circular buffer with log2(IN_DEPTH)-bit read and write pointers.
  - `count` is log2(IN_DEPTH)+1 bits wide; pointers wrap modulo IN_DEPTH.
  - `ext_in_ready` = (count < IN_DEPTH).
  - push = `ext_in_valid` & `ext_in_ready`.
  - pop = `in_strobe` & (count != 0).
  - `in_data` = mem[rd_ptr] when count != 0, else 0.
  - stall_in = `in_strobe` & (count == 0). There is no bypass: a word pushed into an empty FIFO is readable on the next cycle.
- Simultaneous push and pop: both pointers advance and count is unchanged. When full, a same-cycle pop does not raise `ext_in_ready`, because ready depends only on the registered count.
- `stall` = stall_in | stall_out.
- Both strobes active in the same cycle (illegal from the decoder) still has defined behaviour: each side evaluates independently and `stall` is the OR of the two conditions.
- An `ext_out_valid`/`ext_out_data` pair is never retracted or changed while `ext_out_ready` is low.

## Timing
- All outputs are registered or derived from registers, except these four, which are combinational from inputs and state:
  - `stall`
  - `in_data`
  - `ext_out_valid`
  - `ext_in_ready`
- Reset values: state = OUT_IDLE, `ext_out_valid` = 0, `ext_out_data` = 0, count = 0, pointers = 0, `ext_in_ready` = 1, `stall` = 0 when no strobe is active, `in_data` = 0.
- Output-store latency: `ext_out_valid` rises 1 cycle after an accepted strobe.
- Input latency: an external word is visible on `in_data` 1 cycle after its push.
- Reset asserted mid-transfer discards the held output word and all FIFO contents immediately. No handshake completes during reset.
- Throughput: with `ext_out_ready` tied high, one output-store per cycle without stall. With `ext_in_valid` tied high, one input-load per cycle once the FIFO is non-empty.

## Configuration
- `IO_PORT_CNT_EN` defined:
  - Adds two 16-bit outputs, `tx_count` and `rx_count`, each reset to 0.
  - `tx_count` increments on every external output handshake (`ext_out_valid` & `ext_out_ready`).
  - `rx_count` increments on every push.
  - Both counters wrap from 0xFFFF to 0.
- `IO_PORT_CNT_EN` undefined: the ports and logic are absent, and all other behaviour is identical.

## Structure
- The shared package holds `IO_FUNCT3` = 3'b111, the output-FSM state enum (OUT_IDLE, OUT_FULL), and the default `DATA_W`.
- One sub-module, `io_in_fifo`: a parameterised synchronous FIFO providing push/pop/count/full/empty, instantiated for the input path.
- The output FSM stays inline in `io_port_ctrl`.

## Test plan
- Reset then idle:
  - `ext_in_ready` = 1, `ext_out_valid` = 0, `stall` = 0.
  - Assert `in_strobe` → `stall` = 1 and `in_data` = 0 until a word arrives.
- Push 0xA5A5_0001 with `in_strobe` held: `stall` is high in cycle 0 and low in cycle 1 with `in_data` = 0xA5A5_0001. After the pop edge, count = 0.
- Fill the FIFO with 4 words (1, 2, 3, 4):
  - `ext_in_ready` = 0 after the 4th word.
  - A 5th word (5) held valid is not accepted.
  - Four pops return 1, 2, 3, 4 in order; pointer wrap is checked by a further 6 push/pop pairs.
- Output with `ext_out_ready` = 0: store 0x1234 → `ext_out_valid` = 1 next cycle. A second store 0x5678 stalls with `ext_out_data` holding 0x1234. Raise `ext_out_ready` → 0x1234 handshakes, 0x5678 is captured the same edge, and `stall` drops.
- Simultaneous push and pop at count = 2 → count stays 2 and data order is preserved. Assert `rst_n` = 0 mid-burst → count = 0 and `ext_out_valid` = 0 asynchronously.
- With `IO_PORT_CNT_EN` defined: 3 output handshakes and 5 pushes → `tx_count` = 3, `rx_count` = 5. Preload near wrap (or force) → the counter rolls from 0xFFFF to 0.
